uart_tx: RTL and testbench

//   UART transmitter that consumes the baud clock from the baud-rate generator.
//   It serialises one parallel word per frame (start, data LSB-first, optional parity, stop).

---
 rtl/uart_tx.sv | 155 +++++++++++++++
 tb/tb_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
// baud_clk is synchronised into clk and edge-detected into a one-cycle bit tick.
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    typedef enum logic [2:0] {
        IDLE,
        PENDING,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t               state, state_n;
    logic                 sync1_q, sync2_q, prev_q;
    logic                 baud_tick;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic [2:0]           bit_cnt_q, bit_cnt_n;
    logic                 stop_cnt_q, stop_cnt_n;
    logic                 par_q, par_n;
    logic                 tx_q, tx_n;
    logic                 done_q, done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= baud_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign baud_tick = sync2_q & ~prev_q;

    always_comb begin
        state_n    = state;
        shift_n    = shift_q;
        bit_cnt_n  = bit_cnt_q;
        stop_cnt_n = stop_cnt_q;
        par_n      = par_q;
        tx_n       = tx_q;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                // Parity is taken from the word at the handshake, not the live input.
                if (tx_valid) begin
                    state_n = PENDING;
                    shift_n = tx_data;
                    par_n   = (^tx_data) ^ (PARITY_ODD != 0);
                end
            end
            PENDING: begin
                if (baud_tick) begin
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_n   = DATA;
                    tx_n      = shift_q[0];
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            tx_n    = par_q;
                        end else begin
                            state_n    = STOP;
                            tx_n       = 1'b1;
                            stop_cnt_n = '0;
                        end
                    end else begin
                        shift_n   = shift_q >> 1;
                        tx_n      = shift_q[1];
                        bit_cnt_n = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_n    = STOP;
                    tx_n       = 1'b1;
                    stop_cnt_n = '0;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (baud_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        stop_cnt_n = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            shift_q    <= shift_n;
            bit_cnt_q  <= bit_cnt_n;
            stop_cnt_q <= stop_cnt_n;
            par_q      <= par_n;
            tx_q       <= tx_n;
            done_q     <= done_n;
        end
    end

    assign tx_ready = (state == IDLE);
    assign tx_busy  = ~tx_ready;
    assign tx_done  = done_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four parameterisations share clk/baud_clk/rst;
// expected line waveforms are queued as strings and checked cycle-by-cycle by per-instance monitors.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       baud_clk;
    logic [7:0] data_w [4];
    logic [3:0] valid_w;
    logic [3:0] ready_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;
    logic [3:0] tx_w;

    string       exp_q [4][$];
    int unsigned checks;
    int unsigned errors;
    int unsigned cyc;
    int unsigned rise_cyc;

    uart_tx u_a (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(data_w[0]),
        .tx_valid(valid_w[0]), .tx_ready(ready_w[0]), .tx_busy(busy_w[0]),
        .tx_done(done_w[0]), .tx(tx_w[0])
    );

    uart_tx #(.PARITY_EN(1)) u_b (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(data_w[1]),
        .tx_valid(valid_w[1]), .tx_ready(ready_w[1]), .tx_busy(busy_w[1]),
        .tx_done(done_w[1]), .tx(tx_w[1])
    );

    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(data_w[2]),
        .tx_valid(valid_w[2]), .tx_ready(ready_w[2]), .tx_busy(busy_w[2]),
        .tx_done(done_w[2]), .tx(tx_w[2])
    );

    uart_tx #(.DATA_BITS(5)) u_d (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(data_w[3][4:0]),
        .tx_valid(valid_w[3]), .tx_ready(ready_w[3]), .tx_busy(busy_w[3]),
        .tx_done(done_w[3]), .tx(tx_w[3])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // baud_clk: period 16 clk, changes on the falling clk edge
    initial begin
        int unsigned ph;
        ph       = 0;
        baud_clk = 1'b0;
        rise_cyc = 0;
        forever begin
            @(negedge clk);
            ph++;
            if (ph == 8) begin
                ph       = 0;
                baud_clk = ~baud_clk;
                if (baud_clk) rise_cyc = cyc;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_mon
        initial begin
            string       f;
            bit          prev;
            bit          early;
            bit          aborted;
            int unsigned idle;
            int unsigned n;
            int unsigned mism;
            prev = 1'b1;
            idle = 1000;
            forever begin
                @(negedge clk);
                if (rst) begin
                    prev = 1'b1;
                    idle = 1000;
                    continue;
                end
                if (done_w[g]) chk($sformatf("spurious_done[%0d]", g), 1, 0);
                if (prev && !tx_w[g]) begin
                    chk($sformatf("start_latency[%0d]", g), int'(cyc - rise_cyc), 3);
                    chk($sformatf("gap_ge_16[%0d] idle=%0d", g, idle), int'(idle >= 16), 1);
                    if (exp_q[g].size() == 0) begin
                        chk($sformatf("unexpected_frame[%0d]", g), 1, 0);
                        prev = tx_w[g];
                        idle = 0;
                        continue;
                    end
                    f       = exp_q[g].pop_front();
                    n       = f.len() * 16;
                    early   = 1'b0;
                    aborted = 1'b0;
                    mism    = 0;
                    for (int unsigned k = 0; k <= n; k++) begin
                        if (k != 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (k == n) begin
                            chk($sformatf("done_at_end[%0d]", g), done_w[g], 1);
                            chk($sformatf("ready_at_end[%0d]", g), ready_w[g], 1);
                        end else begin
                            if (tx_w[g] != (f[k/16] == "1")) mism++;
                            if (done_w[g]) early = 1'b1;
                            if (k % 16 == 15) begin
                                chk($sformatf("inst%0d %s bit%0d bad_samples", g, f, k/16), int'(mism), 0);
                                mism = 0;
                            end
                        end
                    end
                    if (aborted) begin
                        prev = 1'b1;
                        idle = 1000;
                        continue;
                    end
                    chk($sformatf("early_done[%0d]", g), early, 0);
                    idle = 1;
                end else begin
                    idle++;
                end
                prev = tx_w[g];
            end
        end
    end

    task automatic send(input int idx, input logic [7:0] d, input string frame);
        int unsigned t;
        @(negedge clk);
        t = 0;
        while (!ready_w[idx] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("ready_before_send[%0d]", idx), ready_w[idx], 1);
        exp_q[idx].push_back(frame);
        data_w[idx]  = d;
        valid_w[idx] = 1'b1;
        @(negedge clk);
        valid_w[idx] = 1'b0;
        chk($sformatf("accepted[%0d]", idx), busy_w[idx], 1);
    endtask

    task automatic wait_idle(input int idx);
        int unsigned t;
        t = 0;
        while ((exp_q[idx].size() != 0 || busy_w[idx]) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("frame_finished[%0d]", idx), int'(t < 5000), 1);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int unsigned t;
        bit          done_seen;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        valid_w = '0;
        for (int i = 0; i < 4; i++) data_w[i] = 8'h00;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_tx[%0d]", i), tx_w[i], 1);
            chk($sformatf("rst_ready[%0d]", i), ready_w[i], 1);
            chk($sformatf("rst_busy[%0d]", i), busy_w[i], 0);
            chk($sformatf("rst_done[%0d]", i), done_w[i], 0);
        end
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // defaults: 0xA5
        send(0, 8'hA5, "0101001011");
        wait_idle(0);

        // parity variants
        send(1, 8'hA5, "01010010101");
        wait_idle(1);
        send(2, 8'hA5, "010100101111");
        wait_idle(2);
        send(2, 8'h01, "010000000011");
        wait_idle(2);

        // valid held through frame, data changes mid-frame
        exp_q[0].push_back("0001111001");
        exp_q[0].push_back("0111111111");
        @(negedge clk);
        data_w[0]  = 8'h3C;
        valid_w[0] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!busy_w[0] && t < 100);
        chk("hold_first_accept", busy_w[0], 1);
        repeat (60) @(negedge clk);
        data_w[0] = 8'hFF;
        t = 0;
        while (!done_w[0] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("hold_first_done", done_w[0], 1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!busy_w[0] && t < 100);
        chk("hold_second_accept", busy_w[0], 1);
        valid_w[0] = 1'b0;
        wait_idle(0);
        repeat (40) @(negedge clk);

        // reset during data bit 3 of 0xF0 (line low there)
        send(0, 8'hF0, "0000011111");
        t = 0;
        while (tx_w[0] && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("abort_start_seen", tx_w[0], 0);
        repeat (72) @(negedge clk);
        chk("abort_bit3_low", tx_w[0], 0);
        rst = 1'b1;
        #1;
        chk("abort_tx", tx_w[0], 1);
        chk("abort_ready", ready_w[0], 1);
        chk("abort_busy", busy_w[0], 0);
        chk("abort_done", done_w[0], 0);
        done_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            done_seen |= done_w[0];
        end
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            done_seen |= done_w[0];
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_queue_empty", exp_q[0].size(), 0);
        send(0, 8'h00, "0000000001");
        wait_idle(0);

        // 5 data bits; upper tx_data bits not connected to the frame
        send(3, 8'h15, "0101011");
        wait_idle(3);
        send(3, 8'hEA, "0010101");
        wait_idle(3);

        for (int i = 0; i < 4; i++)
            chk($sformatf("queue_empty[%0d]", i), exp_q[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
